rotor_btof_diff: RTL and testbench

Sequenced backward-path (reflector-to-entry) rotor engine for the Enigma datapath. It is the return-direction counterpart of the forward (entry-to-reflector) difference-encoded rotor path. It accepts a 6-bit symbol from the reflector and walks it back through rotor 2, rotor 1, then rotor 0, one rotor per clock, using inverse difference tables. It returns the symbol the forward path would have consumed, behind a valid/ready handshake on both sides.

---
 rtl/enigma_pkg.sv | 58 +++++
 rtl/rotor_bwd_lut.sv | 29 ++
 rtl/rotor_btof_diff.sv | 116 +++++++++++
 tb/tb_rotor_btof_diff.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/enigma_pkg.sv
// Shared Enigma datapath definitions: symbol width, FSM encoding and the rotor
// difference tables used by both the forward and the backward rotor paths.
package enigma_pkg;

    localparam int W       = 6;
    localparam int N_SYM   = 1 << W;
    localparam int N_ROTOR = 3;

    typedef logic [W-1:0] sym_t;
    typedef logic [N_ROTOR-1:0][N_SYM-1:0][W-1:0] diff_tab_t;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_S2   = 3'd1;
    localparam logic [2:0] ST_S1   = 3'd2;
    localparam logic [2:0] ST_S0   = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    // Rotor wiring: an odd-multiplier affine map followed by an XOR, which is
    // always a bijection on the 2^W alphabet.
    function automatic sym_t fwd_wiring(input int k, input int a);
        sym_t b;
        case (k)
            0:       b = sym_t'(5 * a + 17)  ^ sym_t'(6'h2a);
            1:       b = sym_t'(11 * a + 3)  ^ sym_t'(6'h15);
            default: b = sym_t'(37 * a + 41) ^ sym_t'(6'h33);
        endcase
        return b;
    endfunction

    function automatic diff_tab_t build_fwd();
        diff_tab_t t;
        t = '0;
        for (int k = 0; k < N_ROTOR; k++) begin
            for (int a = 0; a < N_SYM; a++) begin
                t[2'(k)][sym_t'(a)] = fwd_wiring(k, a) - sym_t'(a);
            end
        end
        return t;
    endfunction

    // The inverse is derived from the same wiring so the two tables cannot drift.
    function automatic diff_tab_t build_bwd();
        diff_tab_t t;
        sym_t      b;
        t = '0;
        for (int k = 0; k < N_ROTOR; k++) begin
            for (int a = 0; a < N_SYM; a++) begin
                b = fwd_wiring(k, a);
                t[2'(k)][b] = sym_t'(a) - b;
            end
        end
        return t;
    endfunction

    localparam diff_tab_t FWD_DIFF = build_fwd();
    localparam diff_tab_t BWD_DIFF = build_bwd();

endpackage

// File: rtl/rotor_bwd_lut.sv
// Combinational inverse-difference lookup for one rotor, selected by index.
// Shared by all three backward rotor steps.
module rotor_bwd_lut
    import enigma_pkg::*;
(
    input  logic [1:0]   rotor,
    input  logic [W-1:0] c,
    output logic [W-1:0] diff
);

    logic [W-1:0] per_rotor [N_ROTOR];

    generate
        for (genvar gi = 0; gi < N_ROTOR; gi++) begin : g_rotor
            assign per_rotor[gi] = BWD_DIFF[gi][c];
        end
    endgenerate

    always_comb begin
        diff = '0;
        case (rotor)
            2'd0:    diff = per_rotor[0];
            2'd1:    diff = per_rotor[1];
            2'd2:    diff = per_rotor[2];
            default: diff = '0;
        endcase
    end

endmodule

// File: rtl/rotor_btof_diff.sv
// Backward (reflector-to-entry) rotor engine: walks one symbol through rotors
// 2, 1, 0 using inverse difference tables, one rotor per clock.
module rotor_btof_diff
    import enigma_pkg::*;
#(
    parameter int W = enigma_pkg::W
)
(
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] data_in,
    input  logic [W-1:0] r0_position,
    input  logic [W-1:0] r1_position,
    input  logic [W-1:0] r2_position,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] data_out,
    output logic         busy
);

    logic [2:0]   state_reg;
    logic [W-1:0] x_reg;
    logic [W-1:0] p0_reg;
    logic [W-1:0] p1_reg;
    logic [W-1:0] p2_reg;

    logic [1:0]   rotor_sel;
    logic [W-1:0] pk;
    logic [W-1:0] contact;
    logic [W-1:0] diff;
    logic [W-1:0] x_next;

    // The state selects which rotor the single lookup serves this cycle.
    always_comb begin
        rotor_sel = 2'd0;
        pk        = p0_reg;
        case (state_reg)
            ST_S2: begin
                rotor_sel = 2'd2;
                pk        = p2_reg;
            end
            ST_S1: begin
                rotor_sel = 2'd1;
                pk        = p1_reg;
            end
            default: begin
                rotor_sel = 2'd0;
                pk        = p0_reg;
            end
        endcase
    end

    assign contact = x_reg + pk;
    assign x_next  = contact + diff - pk;

    rotor_bwd_lut u_lut (
        .rotor (rotor_sel),
        .c     (contact),
        .diff  (diff)
    );

    assign in_ready = (state_reg == ST_IDLE);
    assign busy     = (state_reg != ST_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            x_reg     <= '0;
            p0_reg    <= '0;
            p1_reg    <= '0;
            p2_reg    <= '0;
            data_out  <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (in_valid) begin
                        x_reg     <= data_in;
                        p0_reg    <= r0_position;
                        p1_reg    <= r1_position;
                        p2_reg    <= r2_position;
                        state_reg <= ST_S2;
                    end
                end
                ST_S2: begin
                    x_reg     <= x_next;
                    state_reg <= ST_S1;
                end
                ST_S1: begin
                    x_reg     <= x_next;
                    state_reg <= ST_S0;
                end
                ST_S0: begin
                    x_reg     <= x_next;
                    data_out  <= x_next;
                    out_valid <= 1'b1;
                    state_reg <= ST_DONE;
                end
                ST_DONE: begin
                    // data_out is left untouched so it stays stable under backpressure.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state_reg <= ST_IDLE;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rotor_btof_diff.sv
// Bench for rotor_btof_diff: symbols are forward-encoded by a reference model
// and the engine must return the original symbol.
module tb_rotor_btof_diff;
    import enigma_pkg::*;

    localparam int SW = enigma_pkg::W;
    localparam int NS = 1 << SW;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [SW-1:0] data_in;
    logic [SW-1:0] r0_position;
    logic [SW-1:0] r1_position;
    logic [SW-1:0] r2_position;
    logic          out_valid;
    logic          out_ready;
    logic [SW-1:0] data_out;
    logic          busy;

    int n_checks = 0;
    int n_fail   = 0;
    int n_txn    = 0;

    rotor_btof_diff dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .data_in     (data_in),
        .r0_position (r0_position),
        .r1_position (r1_position),
        .r2_position (r2_position),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .data_out    (data_out),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int observed, input int expected);
        n_checks++;
        if (observed !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Forward (entry-to-reflector) path through rotors 0,1,2 in plain integer arithmetic.
    function automatic int fwd_path(input int s, input int q0, input int q1, input int q2);
        int x;
        int c;
        int p [3];
        p[0] = q0;
        p[1] = q1;
        p[2] = q2;
        x = s;
        for (int k = 0; k < 3; k++) begin
            c = (x + p[k]) % NS;
            c = (c + int'(FWD_DIFF[2'(k)][6'(c)])) % NS;
            x = (c - p[k] + NS) % NS;
        end
        return x;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_txn(input int orig, input int q0, input int q1, input int q2,
                           input int stall, input bit perturb);
        int din;
        int lat;
        int held;
        din = fwd_path(orig, q0, q1, q2);
        check("idle_in_ready", int'(in_ready), 1);
        in_valid    = 1'b1;
        data_in     = 6'(din);
        r0_position = 6'(q0);
        r1_position = 6'(q1);
        r2_position = 6'(q2);
        tick();
        in_valid = 1'b0;
        if (perturb) begin
            r0_position = 6'($urandom);
            r1_position = 6'd40;
            r2_position = 6'($urandom);
        end
        lat = 0;
        while (!out_valid && lat < 10) begin
            tick();
            lat++;
        end
        check("latency", lat, 3);
        check("data_out", int'(data_out), orig);
        held = int'(data_out);
        for (int i = 0; i < stall; i++) begin
            in_valid = 1'b1;
            data_in  = 6'($urandom);
            tick();
            check("stall_hold", int'(data_out), held);
            check("stall_in_ready", int'(in_ready), 0);
            check("stall_out_valid", int'(out_valid), 1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("release_out_valid", int'(out_valid), 0);
        check("release_in_ready", int'(in_ready), 1);
        n_txn++;
        $display("txn %0d: orig=%0d din=%0d pos=%0d/%0d/%0d stall=%0d lat=%0d dout=%0d",
                 n_txn, orig, din, q0, q1, q2, stall, lat, held);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int b;
        int pos_sets [3][3];
        pos_sets = '{'{0, 0, 0}, '{1, 2, 3}, '{63, 63, 63}};

        rst         = 1'b1;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        data_in     = '0;
        r0_position = '0;
        r1_position = '0;
        r2_position = '0;
        tick();
        tick();
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_data_out", int'(data_out), 0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        check("post_rst_in_ready", int'(in_ready), 1);
        check("post_rst_busy", int'(busy), 0);

        // Inverse-table property over the whole package.
        for (int k = 0; k < 3; k++) begin
            for (int a = 0; a < NS; a++) begin
                b = (a + int'(FWD_DIFF[2'(k)][6'(a)])) % NS;
                check("bwd_table", int'(BWD_DIFF[2'(k)][6'(b)]), (a - b + NS) % NS);
            end
        end

        // Directed corners: wrap at 63, the 5/9/63 example, position capture 4 -> 40.
        run_txn(17, 5, 9, 63, 0, 1'b0);
        run_txn(63, 1, 1, 1, 0, 1'b0);
        run_txn(0, 63, 63, 63, 0, 1'b0);
        run_txn(22, 7, 4, 12, 0, 1'b1);
        run_txn(45, 30, 31, 32, 5, 1'b1);

        // Round trip over the whole alphabet for each position set.
        for (int s = 0; s < 3; s++) begin
            for (int v = 0; v < NS; v++) begin
                run_txn(v, pos_sets[s][0], pos_sets[s][1], pos_sets[s][2], 0, 1'b0);
            end
        end

        for (int i = 0; i < 40; i++) begin
            run_txn(int'($urandom_range(NS - 1)), int'($urandom_range(NS - 1)),
                    int'($urandom_range(NS - 1)), int'($urandom_range(NS - 1)),
                    int'($urandom_range(5)), 1'($urandom));
        end

        // Reset while in S1 discards the symbol and clears outputs immediately.
        in_valid    = 1'b1;
        data_in     = 6'd33;
        r0_position = 6'd3;
        r1_position = 6'd8;
        r2_position = 6'd21;
        tick();
        in_valid = 1'b0;
        tick();
        check("mid_busy_before_rst", int'(busy), 1);
        rst = 1'b1;
        #1;
        check("mid_rst_out_valid", int'(out_valid), 0);
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_data_out", int'(data_out), 0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        tick();
        check("mid_rst_no_output", int'(out_valid), 0);
        run_txn(38, 11, 22, 33, 2, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
